// File: rtl/csa_pipe_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csa_pipe_addsub: two-stage pipelined carry-select adder/subtractor.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module csa_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_BLK = (BLK < 1) ? 1 : BLK;
  localparam int c_NB  = WIDTH / c_BLK;

  if ((BLK < 1) || ((WIDTH % c_BLK) != 0)) begin : g_param_err
    $error("csa_pipe_addsub: BLK must be >= 1 and divide WIDTH");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  logic [WIDTH-1:0] w_s0, w_s1;
  logic [c_NB-1:0]  w_co0, w_co1;
  logic             w_cm0, w_cm1;

  logic             r_v1;
  logic [WIDTH-1:0] r_s0, r_s1;
  logic [c_NB-1:0]  r_co0, r_co1;
  logic             r_c0, r_cm0, r_cm1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf;

  logic [WIDTH-1:0] w_sum;
  logic             w_cy, w_ctop, w_cmsb;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_bx = b ^ {WIDTH{sub}};
  assign w_c0 = cin ^ sub;

  for (genvar k = 0; k < c_NB; k++) begin : g_blk
    logic [c_BLK:0] w_t0, w_t1;
    assign w_t0 = {1'b0, a[k*c_BLK +: c_BLK]} + {1'b0, w_bx[k*c_BLK +: c_BLK]};
    assign w_t1 = w_t0 + {{c_BLK{1'b0}}, 1'b1};
    assign w_s0[k*c_BLK +: c_BLK] = w_t0[c_BLK-1:0];
    assign w_s1[k*c_BLK +: c_BLK] = w_t1[c_BLK-1:0];
    assign w_co0[k] = w_t0[c_BLK];
    assign w_co1[k] = w_t1[c_BLK];
  end

  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
  assign w_cm0 = w_s0[WIDTH-1] ^ a[WIDTH-1] ^ w_bx[WIDTH-1];
  assign w_cm1 = w_s1[WIDTH-1] ^ a[WIDTH-1] ^ w_bx[WIDTH-1];

  // Block carry select chain; w_ctop ends as the carry into the top block.
  always_comb begin
    w_sum  = '0;
    w_cy   = r_c0;
    w_ctop = 1'b0;
    for (int k = 0; k < c_NB; k++) begin
      w_ctop = w_cy;
      w_sum[k*c_BLK +: c_BLK] = w_cy ? r_s1[k*c_BLK +: c_BLK] : r_s0[k*c_BLK +: c_BLK];
      w_cy = w_cy ? r_co1[k] : r_co0[k];
    end
  end

  assign w_cmsb = w_ctop ? r_cm1 : r_cm0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1        <= 1'b0;
      r_s0        <= '0;
      r_s1        <= '0;
      r_co0       <= '0;
      r_co1       <= '0;
      r_c0        <= 1'b0;
      r_cm0       <= 1'b0;
      r_cm1       <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_v1        <= in_valid;
      r_s0        <= w_s0;
      r_s1        <= w_s1;
      r_co0       <= w_co0;
      r_co1       <= w_co1;
      r_c0        <= w_c0;
      r_cm0       <= w_cm0;
      r_cm1       <= w_cm1;
      r_out_valid <= r_v1;
      r_sum       <= w_sum;
      r_cout      <= w_cy;
      r_ovf       <= w_cmsb ^ w_cy;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_csa_pipe_addsub: scoreboard bench for csa_pipe_addsub.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_csa_pipe_addsub;
  localparam int W = 16;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks = 0;
  int   errors = 0;
  logic rnd_ready = 1'b0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];

  csa_pipe_addsub #(.WIDTH(W), .BLK(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk16(input string n, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, req);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", n, act, req);
    end
  endtask

  // Reference: integer arithmetic on the operands' unsigned and signed values.
  function automatic exp_t model(input logic [W-1:0] pa, input logic [W-1:0] pb,
                                 input logic pc, input logic ps);
    longint ua, ub, sa, sb, ci, r, sr, lim;
    exp_t   m;
    lim = longint'(1) << W;
    ua  = longint'(pa);
    ub  = longint'(pb);
    sa  = longint'($signed(pa));
    sb  = longint'($signed(pb));
    ci  = longint'(pc);
    if (ps) begin
      r   = ua - ub - ci;
      sr  = sa - sb - ci;
      m.c = (r >= 0);
    end else begin
      r   = ua + ub + ci;
      sr  = sa + sb + ci;
      m.c = (r >= lim);
    end
    m.s = r[W-1:0];
    m.o = (sr > (lim / 2 - 1)) || (sr < -(lim / 2));
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input logic [W-1:0] pa, input logic [W-1:0] pb,
                       input logic pc, input logic ps);
    a = pa; b = pb; cin = pc; sub = ps; in_valid = 1'b1;
  endtask

  task automatic send_exp(input logic [W-1:0] pa, input logic [W-1:0] pb,
                          input logic pc, input logic ps, input exp_t e);
    drive(pa, pb, pc, ps);
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(e);
        tick();
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready=0 for 200 cycles required acceptance");
  endtask

  task automatic send(input logic [W-1:0] pa, input logic [W-1:0] pb,
                      input logic pc, input logic ps);
    send_exp(pa, pb, pc, ps, model(pa, pb, pc, ps));
  endtask

  task automatic drain();
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d beats outstanding required 0", exp_q.size());
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: pops the scoreboard on every output transfer, checks held data under stall.
  initial begin : monitor
    logic         hold;
    logic [W-1:0] hs;
    logic         hc, ho;
    exp_t         e;
    hold = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk1("held_valid", out_valid, 1'b1);
          chk16("held_sum", sum, hs);
          chk1("held_cout", cout, hc);
          chk1("held_ovf", ovf, ho);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got sum %h with no beat pending required none", sum);
          end else begin
            e = exp_q.pop_front();
            chk16("sum", sum, e.s);
            chk1("cout", cout, e.c);
            chk1("ovf", ovf, e.o);
          end
        end
        hold = out_valid && !out_ready;
        hs = sum; hc = cout; ho = ovf;
      end
    end
  end

  localparam int ND = 8;
  logic [W-1:0] d_a [ND] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007, 16'h0FFF, 16'h0000, 16'h8000};
  logic [W-1:0] d_b [ND] = '{16'h0001, 16'h0001, 16'h8000, 16'h0007, 16'h0005, 16'hF000, 16'h0000, 16'h0001};
  logic         d_c [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic         d_s [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] d_rs[ND] = '{16'h0000, 16'h8000, 16'h0000, 16'hFFFE, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF};
  logic         d_rc[ND] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic         d_ro[ND] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin : main
    exp_t e0, e;
    tick();
    tick();
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_sum", sum, '0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    #1;
    chk1("in_ready_after_reset", in_ready, 1'b1);
    tick();

    // Directed vectors with hand-derived results, streamed back to back.
    for (int i = 0; i < ND; i++) begin
      e.s = d_rs[i]; e.c = d_rc[i]; e.o = d_ro[i];
      send_exp(d_a[i], d_b[i], d_c[i], d_s[i], e);
    end
    drain();

    // Backpressure: stall with two beats in flight, then release.
    out_ready = 1'b1;
    e0 = model(16'h1234, 16'h1111, 1'b0, 1'b0);
    drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    #1; chk1("bp_accept0", in_ready, 1'b1); exp_q.push_back(e0);
    tick();
    out_ready = 1'b0;
    drive(16'h4000, 16'h0001, 1'b1, 1'b1);
    #1; chk1("bp_accept1", in_ready, 1'b1); exp_q.push_back(model(16'h4000, 16'h0001, 1'b1, 1'b1));
    tick();
    drive(16'hABCD, 16'h5432, 1'b1, 1'b0);
    #1;
    chk1("bp_stall_ready", in_ready, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    chk16("bp_first_sum", sum, e0.s);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("bp_hold_ready", in_ready, 1'b0);
      chk16("bp_hold_sum", sum, e0.s);
      tick();
    end
    out_ready = 1'b1;
    #1; chk1("bp_release_ready", in_ready, 1'b1); exp_q.push_back(model(16'hABCD, 16'h5432, 1'b1, 1'b0));
    tick();
    drive(16'h0001, 16'hFFFF, 1'b0, 1'b1);
    #1;
    chk1("bp_accept3", in_ready, 1'b1);
    chk1("bp_stream1", out_valid, 1'b1);
    exp_q.push_back(model(16'h0001, 16'hFFFF, 1'b0, 1'b1));
    tick();
    in_valid = 1'b0;
    #1; chk1("bp_stream2", out_valid, 1'b1);
    tick();
    #1; chk1("bp_stream3", out_valid, 1'b1);
    tick();
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b1;
    drive(16'h2222, 16'h3333, 1'b0, 1'b0);
    tick();
    drive(16'h4444, 16'h5555, 1'b0, 1'b0);
    tick();
    chk1("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk16("midrst_sum", sum, '0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1; chk1("rst_no_stale", out_valid, 1'b0);
    end
    tick();
    send(16'h00FF, 16'h0F01, 1'b1, 1'b0);
    drain();

    // Randomised traffic with bubbles and random downstream stalls.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csa_pipe_addsub.md
Name: csa_pipe_addsub

Overview:
- Parametrised, two-stage pipelined carry-select adder/subtractor with a valid/ready stream on input and output.
- Operands are split into WIDTH/BLK blocks. For each block, stage 1 precomputes the sums and carries for carry-in 0 and for carry-in 1.
- Stage 2 resolves the block carry chain through muxes and registers the result.
- Used as the datapath adder in streaming arithmetic units where the ripple carry would otherwise limit clock frequency.

Parameters:
- WIDTH, 16, operand and result width in bits.
- BLK, 4, carry-select block width in bits. WIDTH % BLK != 0 or BLK < 1 is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts operand beat this cycle
- a  input  WIDTH  operand A (two's complement or unsigned)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) or borrow-in (sub)
- sub  input  1  0 = A+B+cin, 1 = A-B-cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out; in sub mode, 1 = no borrow
- ovf  output  1  signed overflow

Behaviour:
- Reset (asynchronous, active-low):
  - stage-1 valid, out_valid, sum, cout and ovf clear to 0 immediately.
  - In-flight beats are discarded.
  - in_ready is 1 one cycle after deassertion, and stays 1 while the pipe is not stalled.
- Operand conditioning (combinational, stage 1):
  - bx = b XOR {WIDTH{sub}}
  - c0 = cin XOR sub
  - Result: sub=1, cin=0 gives A-B; sub=1, cin=1 gives A-B-1.
- Stage 1 (registered on advance), for each block k in 0..WIDTH/BLK-1:
  - Ripple sum s0_k and carry co0_k assuming block carry-in 0.
  - Ripple sum s1_k and carry co1_k assuming block carry-in 1.
  - Also registered: c0, and the carries into the MSB under both assumptions for the top block.
- Stage 2 (registered on advance):
  - cblk_0 = registered c0.
  - sum block k = cblk_k ? s1_k : s0_k.
  - cblk_{k+1} = cblk_k ? co1_k : co0_k.
  - cout = cblk_{WIDTH/BLK}.
  - ovf = (carry into bit WIDTH-1) XOR cout.
- Arithmetic:
  - Modulo 2^WIDTH; all ports are unsigned bit vectors.
  - ovf is meaningful only for signed interpretation, but is always computed.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - Both stages shift together when advance=1.
  - Input is accepted when in_valid & in_ready.
  - Stage-1 valid loads in_valid on advance.
  - out_valid loads stage-1 valid on advance.
  - When advance=0, all registers hold. sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
  - Data registers may load on advance regardless of valid; outputs are only meaningful while out_valid=1.
- Latency and throughput:
  - Accepted beat appears on out_valid 2 cycles after acceptance.
  - Throughput is 1 beat/cycle with out_ready held high.
  - Bubbles propagate as out_valid=0.
- Boundary cases:
  - in_valid=0 with advance=1 inserts a bubble.
  - Simultaneous accept and output, with out_ready=1 and a full pipe: both occur in the same cycle with no loss.
  - Stall with 2 beats in flight: in_ready=0 and nothing is dropped or duplicated.
  - BLK=WIDTH degenerates to a single-block select, which is legal.
  - BLK=1 is legal.

Test Plan (WIDTH=16, BLK=4):
- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 2 cycles later sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x0007, b=0x0005, cin=1, sub=1 -> sum=0x0001, cout=1.
- Carry across all blocks and cin select: a=0x0FFF, b=0xF000, cin=1, sub=0 -> sum=0x0000, cout=1.
- Backpressure:
  - Send 4 beats back-to-back, holding out_ready=0 from cycle 2.
  - Required: in_ready=0 after 2 beats are in flight; the first result is held stable.
  - Release out_ready: the remaining results arrive in order, 1 per cycle, with no loss or duplicates.
- Reset mid-operation:
  - Assert rst_n=0 with 2 beats in flight.
  - Required: out_valid=0 and sum=0 immediately.
  - After release, no stale beat emerges, and the next accepted beat returns its correct result.
